text_buffer_arbiter: RTL and testbench
======================================

# text_buffer_arbiter

Owns the on-chip character buffer for the 720p text overlay and shares its single RAM port between two users: the video scan (character fetch per glyph cell) and a host write port (valid/ready). Sits in the pixel-clock domain between the video signal generator (sx/sy/de) and the font ROM. Drives the font ROM's character code, cell origin and enable. Also provides a clear-screen sequencer that fills the buffer with a fill character.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines
- SX_BITS, 11, width of sx input
- SY_BITS, 10, width of sy input
- GLYPH_W, 16, glyph cell width in pixels; must be a power of 2
- GLYPH_H, 16, glyph cell height in pixels; must be a power of 2
- CHAR_BITS, 8, character code width
- FILL_CHAR, 8'h20, code written by clear

Ports:
- Clock and reset: one clock, i_clk; reset is synchronous and active-low, i_rst_n.
- i_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous active-low reset
- i_sx  in  SX_BITS  current pixel x
- i_sy  in  SY_BITS  current pixel y
- i_de  in  1  active-video flag aligned with i_sx/i_sy
- i_host_valid  in  1  host write request
- o_host_ready  out  1  host write accepted this cycle if valid
- i_host_col  in  $clog2(COLS)  target column, COLS = H_ACTIVE/GLYPH_W (80)
- i_host_row  in  $clog2(ROWS)  target row, ROWS = V_ACTIVE/GLYPH_H (45)
- i_host_char  in  CHAR_BITS  code to write
- i_clear  in  1  start clear-screen (pulse)
- o_busy  out  1  clear in progress
- o_clear_done  out  1  one-cycle pulse when clear completes
- o_err  out  1  one-cycle pulse when an out-of-range host write is accepted
- o_character  out  CHAR_BITS  code of the current cell, to font ROM
- o_cell_x  out  SX_BITS  cell origin x = col*GLYPH_W
- o_cell_y  out  SY_BITS  cell origin y = row*GLYPH_H
- o_font_en  out  1  font ROM enable

## Operation
- RAM: COLS*ROWS entries (3600) of CHAR_BITS. Single port with synchronous read (1-cycle) and write.
- Address = row*COLS + col. col = i_sx >> log2(GLYPH_W); row = i_sy >> log2(GLYPH_H).
- Video slot: any cycle with i_de=1 and i_sx[log2(GLYPH_W)-1:0]==0. The port reads the current cell. Video always wins; it is never stalled.
- Host slot: every other cycle. o_host_ready = (state==IDLE) && !video_slot && !i_clear && i_rst_n. On valid&&ready the transfer completes and the write happens the same cycle.
- Out-of-range write (col>=COLS or row>=ROWS): the transfer completes, no RAM write occurs, and o_err pulses the next cycle.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on i_clear=1. A host write presented in the same cycle is not accepted (ready low).
  - In CLEAR, FILL_CHAR is written to addresses 0..COLS*ROWS-1, one per non-video cycle. The address counter advances only on writes.
  - After writing the last address, the FSM moves CLEAR→IDLE and o_clear_done pulses.
  - o_busy is high while in CLEAR.
  - i_clear while in CLEAR is ignored.
- Font outputs update once per cell from the video read. o_font_en = i_de delayed 2 cycles.
- Reset values: o_host_ready 0 (combinational, so it is also 0 while reset is asserted), o_busy 0, o_clear_done 0, o_err 0, o_character 0, o_cell_x 0, o_cell_y 0, o_font_en 0. The counter is 0 and state is IDLE.
- Reset mid-clear returns the FSM to IDLE with no o_clear_done pulse. RAM contents are not reset; a partial clear remains.

## Timing
- Video fetch latency:
  - Video slot at cycle T: the address is registered/presented at T and RAM data arrives at T+1.
  - At T+2, o_character, o_cell_x and o_cell_y are registered. They hold until the next cell's T+2.
  - The top level delays hsync/vsync/de by 2 cycles to match.
- A host write at cycle T is visible to any video read at T+1 or later. Slots never coincide, so no collision case exists.
- Clear duration: 3600 writes, plus stalls of 1 cycle per 16 during active video.
- o_err and o_clear_done are exactly 1 cycle wide.

## Structure
- Package text_overlay_pkg holds:
  - state enum {IDLE, CLEAR}
  - GLYPH_W/GLYPH_H defaults
  - FILL_CHAR
  - COLS/ROWS derivation helper functions
- Sub-module text_char_ram: single-port synchronous RAM inferred as block RAM, with parameters DEPTH and WIDTH.
- The arbiter, FSM, address math and output pipeline live in text_buffer_arbiter.

## Test plan
- Reset: hold i_rst_n=0 for 5 cycles with i_host_valid=1 and i_de=1 → every output listed above reads 0 and o_host_ready stays 0.
- Host write col=5, row=2, char=8'h41, then scan a frame → on sy 32..47, at sx=80, o_character=8'h41, o_cell_x=80 and o_cell_y=32 two cycles later.
- Arbitration: hold i_host_valid=1 across an active line → o_host_ready=0 on every cycle with sx%16==0, and 1 on all others; exactly 15 writes land per 16 active cycles.
- Clear: pulse i_clear with the buffer pre-filled with 8'h41 → o_busy rises the next cycle; after completion o_clear_done pulses once and every cell reads 8'h20.
- Out-of-range and collision:
  - Write col=80 → o_err pulses and cell (0,1) is unchanged.
  - i_clear and i_host_valid in the same cycle → the write is not accepted and the clear starts.
- Reset mid-clear: assert i_rst_n=0 at write 1000 → FSM returns to IDLE, o_busy=0, no o_clear_done; addresses 0..999 hold 8'h20 and the rest keep their old data.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared types and geometry helpers for the 720p text overlay.
package text_overlay_pkg;

  // Buffer-ownership states of the arbiter.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int GLYPH_W_DEFAULT = 16;
  localparam int GLYPH_H_DEFAULT = 16;
  localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

  // Character cells per line.
  function automatic int calc_cols(input int h_active, input int glyph_w);
    return h_active / glyph_w;
  endfunction

  // Character rows per frame.
  function automatic int calc_rows(input int v_active, input int glyph_h);
    return v_active / glyph_h;
  endfunction

endpackage

// File: rtl/text_buffer_arbiter_if.sv
// Host write port of the text buffer: valid/ready handshake carrying cell and code.
interface text_buffer_arbiter_if #(
  parameter int COL_BITS  = 7,
  parameter int ROW_BITS  = 6,
  parameter int CHAR_BITS = 8
);
  logic                 i_host_valid;
  logic                 o_host_ready;
  logic [COL_BITS-1:0]  i_host_col;
  logic [ROW_BITS-1:0]  i_host_row;
  logic [CHAR_BITS-1:0] i_host_char;

  modport master (
    output i_host_valid, i_host_col, i_host_row, i_host_char,
    input  o_host_ready
  );

  modport slave (
    input  i_host_valid, i_host_col, i_host_row, i_host_char,
    output o_host_ready
  );
endinterface

// File: rtl/text_char_ram.sv
// Single-port character RAM, read-first, one-cycle synchronous read.
module text_char_ram #(
  parameter int DEPTH = 3600,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write when enabled and always return the addressed word one cycle later.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end
endmodule

// File: rtl/text_buffer_arbiter.sv
// Shares the character RAM between the video scan (priority) and host writes,
// runs the clear-screen sequencer and feeds the font ROM.
module text_buffer_arbiter
  import text_overlay_pkg::*;
#(
  parameter int                   H_ACTIVE  = 1280,
  parameter int                   V_ACTIVE  = 720,
  parameter int                   SX_BITS   = 11,
  parameter int                   SY_BITS   = 10,
  parameter int                   GLYPH_W   = GLYPH_W_DEFAULT,
  parameter int                   GLYPH_H   = GLYPH_H_DEFAULT,
  parameter int                   CHAR_BITS = 8,
  parameter logic [CHAR_BITS-1:0] FILL_CHAR = CHAR_BITS'(FILL_CHAR_DEFAULT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SX_BITS-1:0]   i_sx,
  input  logic [SY_BITS-1:0]   i_sy,
  input  logic                 i_de,
  text_buffer_arbiter_if.slave host,
  input  logic                 i_clear,
  output logic                 o_busy,
  output logic                 o_clear_done,
  output logic                 o_err,
  output logic [CHAR_BITS-1:0] o_character,
  output logic [SX_BITS-1:0]   o_cell_x,
  output logic [SY_BITS-1:0]   o_cell_y,
  output logic                 o_font_en
);
  localparam int COLS      = calc_cols(H_ACTIVE, GLYPH_W);
  localparam int ROWS      = calc_rows(V_ACTIVE, GLYPH_H);
  localparam int DEPTH     = COLS * ROWS;
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int COL_BITS  = $clog2(COLS);
  localparam int ROW_BITS  = $clog2(ROWS);
  localparam int GX        = $clog2(GLYPH_W);
  localparam int GY        = $clog2(GLYPH_H);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [COL_BITS:0]    COLS_LIM  = (COL_BITS + 1)'(COLS);
  localparam logic [ROW_BITS:0]    ROWS_LIM  = (ROW_BITS + 1)'(ROWS);

  state_t                 state_r, state_s;
  logic [ADDR_BITS-1:0]   clr_addr_r, clr_addr_s;
  logic                   clear_done_s;
  logic                   video_slot_s, host_fire_s, host_in_range_s, clr_write_s;
  logic [COL_BITS-1:0]    vid_col_s, vid_col_r;
  logic [ROW_BITS-1:0]    vid_row_s, vid_row_r;
  logic [ADDR_BITS-1:0]   vid_addr_s, host_addr_s;
  logic                   ram_we_s;
  logic [ADDR_BITS-1:0]   ram_addr_s;
  logic [CHAR_BITS-1:0]   ram_wdata_s, ram_rdata_s;
  logic                   vid_rd_r, de_d1_r;

  // The first pixel of every visible glyph cell belongs to the video scan.
  assign video_slot_s = i_de && (i_sx[GX-1:0] == {GX{1'b0}});
  assign vid_col_s    = i_sx[GX +: COL_BITS];
  assign vid_row_s    = i_sy[GY +: ROW_BITS];
  assign vid_addr_s   = ADDR_BITS'(vid_row_s) * ADDR_BITS'(COLS) + ADDR_BITS'(vid_col_s);
  assign host_addr_s  = ADDR_BITS'(host.i_host_row) * ADDR_BITS'(COLS) + ADDR_BITS'(host.i_host_col);

  // A clear request takes the port away from the host in the very cycle it arrives.
  assign host.o_host_ready = (state_r == IDLE) && !video_slot_s && !i_clear && i_rst_n;
  assign host_fire_s       = host.i_host_valid && host.o_host_ready;
  assign host_in_range_s   = ({1'b0, host.i_host_col} < COLS_LIM) &&
                             ({1'b0, host.i_host_row} < ROWS_LIM);
  // Gated by reset so a clear interrupted by reset writes nothing further.
  assign clr_write_s       = (state_r == CLEAR) && !video_slot_s && i_rst_n;

  // Port arbitration: video read, else clear fill, else in-range host write.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = vid_addr_s;
    ram_wdata_s = host.i_host_char;
    if (video_slot_s) begin
      ram_we_s   = 1'b0;
      ram_addr_s = vid_addr_s;
    end else if (clr_write_s) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = clr_addr_r;
      ram_wdata_s = FILL_CHAR;
    end else if (host_fire_s && host_in_range_s) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = host_addr_s;
      ram_wdata_s = host.i_host_char;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  text_char_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CHAR_BITS)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Clear sequencer next state: the fill address only moves on an actual write.
  always_comb begin
    state_s      = state_r;
    clr_addr_s   = clr_addr_r;
    clear_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_clear) begin
          state_s    = CLEAR;
          clr_addr_s = {ADDR_BITS{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_write_s) begin
          if (clr_addr_r == LAST_ADDR) begin
            state_s      = IDLE;
            clr_addr_s   = {ADDR_BITS{1'b0}};
            clear_done_s = 1'b1;
          end else begin
            clr_addr_s = clr_addr_r + ADDR_BITS'(1);
          end
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s    = IDLE;
        clr_addr_s = {ADDR_BITS{1'b0}};
      end
    endcase
  end

  // Sequencer state and status pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      clr_addr_r   <= {ADDR_BITS{1'b0}};
      o_busy       <= 1'b0;
      o_clear_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state_r      <= state_s;
      clr_addr_r   <= clr_addr_s;
      o_busy       <= (state_s == CLEAR);
      o_clear_done <= clear_done_s;
      o_err        <= host_fire_s && !host_in_range_s;
    end
  end

  // Video fetch pipeline: carry the cell position alongside the read, publish both together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vid_rd_r    <= 1'b0;
      vid_col_r   <= {COL_BITS{1'b0}};
      vid_row_r   <= {ROW_BITS{1'b0}};
      de_d1_r     <= 1'b0;
      o_font_en   <= 1'b0;
      o_character <= {CHAR_BITS{1'b0}};
      o_cell_x    <= {SX_BITS{1'b0}};
      o_cell_y    <= {SY_BITS{1'b0}};
    end else begin
      vid_rd_r  <= video_slot_s;
      de_d1_r   <= i_de;
      o_font_en <= de_d1_r;
      if (video_slot_s) begin
        vid_col_r <= vid_col_s;
        vid_row_r <= vid_row_s;
      end
      if (vid_rd_r) begin
        o_character <= ram_rdata_s;
        o_cell_x    <= SX_BITS'({vid_col_r, {GX{1'b0}}});
        o_cell_y    <= SY_BITS'({vid_row_r, {GY{1'b0}}});
      end
    end
  end
endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed bench for text_buffer_arbiter: reset, fetch latency, arbitration,
// clear, out-of-range writes and reset during clear.
module tb_text_buffer_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic        de, clear;
  logic        busy, clear_done, err, font_en;
  logic [7:0]  character;
  logic [10:0] cell_x;
  logic [9:0]  cell_y;
  int          checks = 0;
  int          errors = 0;

  text_buffer_arbiter_if #(.COL_BITS(7), .ROW_BITS(6), .CHAR_BITS(8)) host_bus ();

  text_buffer_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sx         (sx),
    .i_sy         (sy),
    .i_de         (de),
    .host         (host_bus),
    .i_clear      (clear),
    .o_busy       (busy),
    .o_clear_done (clear_done),
    .o_err        (err),
    .o_character  (character),
    .o_cell_x     (cell_x),
    .o_cell_y     (cell_y),
    .o_font_en    (font_en)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic host_write(input int col, input int row, input logic [7:0] ch, output bit ok);
    host_bus.i_host_valid = 1'b1;
    host_bus.i_host_col   = 7'(col);
    host_bus.i_host_row   = 6'(row);
    host_bus.i_host_char  = ch;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = host_bus.o_host_ready;
      tick();
    end
    host_bus.i_host_valid = 1'b0;
  endtask

  task automatic read_cell(input int col, input int row, output logic [7:0] ch);
    sx = 11'(col * 16);
    sy = 10'(row * 16);
    de = 1'b1;
    tick();
    de = 1'b0;
    tick();
    ch = character;
  endtask

  task automatic fill_all(input logic [7:0] ch);
    bit ok;
    int bad = 0;
    for (int a = 0; a < 3600; a++) begin
      host_write(a % 80, a / 80, ch, ok);
      if (!ok) bad++;
    end
    check("fill_accept", bad, 0);
  endtask

  initial begin
    logic [7:0] ch;
    bit         ok;
    int         cnt, bad, acc, wc;
    bit         r;

    // Reset with traffic present.
    rst_n = 1'b0; clear = 1'b0; de = 1'b1; sx = 11'd0; sy = 10'd0;
    host_bus.i_host_valid = 1'b1; host_bus.i_host_col = 7'd1;
    host_bus.i_host_row = 6'd1; host_bus.i_host_char = 8'h11;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_ready", host_bus.o_host_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", clear_done, 0);
      check("rst_err", err, 0);
      check("rst_char", character, 0);
      check("rst_cx", cell_x, 0);
      check("rst_cy", cell_y, 0);
      check("rst_fonten", font_en, 0);
    end
    rst_n = 1'b1; de = 1'b0; host_bus.i_host_valid = 1'b0;
    tick();
    #1;
    check("idle_ready", host_bus.o_host_ready, 1);

    // Pre-fill with 'A' and spot-check.
    fill_all(8'h41);
    read_cell(5, 2, ch);   check("fill_5_2", ch, 8'h41);
    read_cell(79, 44, ch); check("fill_79_44", ch, 8'h41);

    // Clear colliding with a host write.
    host_bus.i_host_valid = 1'b1; host_bus.i_host_col = 7'd3;
    host_bus.i_host_row = 6'd3; host_bus.i_host_char = 8'h55;
    clear = 1'b1;
    #1;
    check("collide_ready", host_bus.o_host_ready, 0);
    tick();
    clear = 1'b0; host_bus.i_host_valid = 1'b0;
    check("busy_rise", busy, 1);
    check("collide_err", err, 0);
    cnt = 0;
    while (!clear_done && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("clear_len", cnt, 3600);
    check("clear_busy_low", busy, 0);
    tick();
    check("clear_done_width", clear_done, 0);
    bad = 0;
    for (int a = 0; a < 3600; a++) begin
      read_cell(a % 80, a / 80, ch);
      if (ch !== 8'h20) bad++;
    end
    check("clear_all_cells", bad, 0);

    // Single write and fetch timing over the cell's 16 lines.
    host_write(5, 2, 8'h41, ok);
    check("w52_accept", ok, 1);
    check("w52_err", err, 0);
    for (int y = 32; y < 48; y++) begin
      de = 1'b0; sx = 11'd0;
      tick(); tick();
      for (int x = 0; x < 128; x++) begin
        sx = 11'(x); sy = 10'(y); de = 1'b1;
        #1;
        if (x == 0)  check("fonten_x0", font_en, 0);
        if (x == 2)  check("fonten_x2", font_en, 1);
        if (x == 66) check("char_c4", character, 8'h20);
        if (x == 66) check("cx_c4", cell_x, 64);
        if (x == 82) check("char_c5", character, 8'h41);
        if (x == 82) check("cx_c5", cell_x, 80);
        if (x == 82) check("cy_c5", cell_y, 32);
        if (x == 98) check("char_c6", character, 8'h20);
        tick();
      end
    end
    de = 1'b0;
    tick(); tick();

    // Arbitration across 32 active cycles on row 40.
    acc = 0; wc = 0;
    host_bus.i_host_valid = 1'b1; host_bus.i_host_row = 6'd40;
    for (int x = 0; x < 32; x++) begin
      sx = 11'(x); sy = 10'd640; de = 1'b1;
      host_bus.i_host_col = 7'(wc); host_bus.i_host_char = 8'(8'h60 + wc);
      #1;
      r = host_bus.o_host_ready;
      check("arb_ready", r, (x % 16) != 0);
      tick();
      if (r) begin acc++; wc++; end
    end
    host_bus.i_host_valid = 1'b0; de = 1'b0;
    tick();
    check("arb_count", acc, 30);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      read_cell(c, 40, ch);
      if (ch !== 8'(8'h60 + c)) bad++;
    end
    check("arb_cells", bad, 0);
    read_cell(30, 40, ch); check("arb_untouched", ch, 8'h20);

    // Out-of-range writes.
    host_write(80, 0, 8'h77, ok);
    check("oor_col_accept", ok, 1);
    check("oor_col_err", err, 1);
    tick();
    check("oor_col_err_width", err, 0);
    read_cell(0, 1, ch); check("oor_cell_0_1", ch, 8'h20);
    host_write(0, 45, 8'h77, ok);
    check("oor_row_err", err, 1);
    tick();
    check("oor_row_err_width", err, 0);

    // Reset after 1000 clear writes.
    fill_all(8'h41);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("mid_busy", busy, 1);
    for (int i = 0; i < 1000; i++) tick();
    check("mid_not_done", clear_done, 0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", clear_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (clear_done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    check("mid_after_quiet", bad, 0);
    #1;
    check("mid_idle_ready", host_bus.o_host_ready, 1);
    bad = 0;
    for (int a = 0; a < 3600; a++) begin
      read_cell(a % 80, a / 80, ch);
      if (ch !== ((a < 1000) ? 8'h20 : 8'h41)) bad++;
    end
    check("mid_partial_clear", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
